// File: rtl/gpu_pkg.sv
// gpu_pkg: shared core/LSU state encodings and fetcher handshake constant
// Contents: core_state_t (scheduler stages), lsu_state_t (per-lane LSU status), FETCHED.
package gpu_pkg;
  typedef enum logic [2:0] {
    CS_IDLE, CS_FETCH, CS_DECODE, CS_REQUEST, CS_WAIT, CS_EXECUTE, CS_UPDATE, CS_DONE
  } core_state_t;
  typedef enum logic [1:0] {LSU_IDLE, LSU_REQUESTING, LSU_WAITING, LSU_DONE} lsu_state_t;
  localparam logic [2:0] FETCHED = 3'd2;
endpackage

// File: rtl/pc_min_select.sv
// pc_min_select: lowest PC among valid lanes and the mask of valid lanes sitting on it
// Ports: pcs (per-lane PCs), valid (non-retired lanes) -> min_pc, mask, any (some lane valid).
module pc_min_select #(
  parameter int T = 4,
  parameter int PC_BITS = 8
) (
  input  logic [T-1:0][PC_BITS-1:0] pcs,
  input  logic [T-1:0]              valid,
  output logic [PC_BITS-1:0]        min_pc,
  output logic [T-1:0]              mask,
  output logic                      any
);
  always_comb begin
    min_pc = '1;
    any = 1'b0;
    mask = '0;
    for (int i = 0; i < T; i++)
      if (valid[i] && (!any || pcs[i] < min_pc)) begin
        min_pc = pcs[i];
        any = 1'b1;
      end
    for (int i = 0; i < T; i++)
      mask[i] = valid[i] && pcs[i] == min_pc;
  end
endmodule

// File: rtl/simt_scheduler.sv
// simt_scheduler: SIMT block scheduler, reconverges divergent lanes on the minimum PC
// Ports: clk, reset (async, active-high); start + thread_count launch a kernel;
//   fetcher_state, decoded_*, lsu_state, next_pc are pipeline feedback;
//   core_state, current_pc, active_mask, done report progress.
// Optional: define SIMT_SCHED_PERF_EN to add perf_cycles, perf_instr, perf_diverge.
module simt_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]     thread_count,
  input  logic [2:0]                             fetcher_state,
  input  logic                                   decoded_mem_read_enable,
  input  logic                                   decoded_mem_write_enable,
  input  logic                                   decoded_ret,
  input  logic [2*THREADS_PER_BLOCK-1:0]         lsu_state,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0]   next_pc,
  output logic [2:0]                             core_state,
  output logic [PC_BITS-1:0]                     current_pc,
  output logic [THREADS_PER_BLOCK-1:0]           active_mask,
  output logic                                   done
`ifdef SIMT_SCHED_PERF_EN
  ,
  output logic [31:0]                            perf_cycles,
  output logic [31:0]                            perf_instr,
  output logic [15:0]                            perf_diverge
`endif
);
  localparam int T = THREADS_PER_BLOCK;
  core_state_t state, state_n;
  logic [T-1:0][PC_BITS-1:0] pcs, pcs_n, nxt;
  logic [T-1:0] retired, retired_n, live, busy, min_mask;
  logic [PC_BITS-1:0] min_pc;
  logic min_any;
  // memory intent is observed through lsu_state, so the decoder's memory bits are informational here
  logic unused_decode;
  assign unused_decode = decoded_mem_read_enable ^ decoded_mem_write_enable;
  assign nxt = next_pc;
  assign core_state = state;
  assign done = state == CS_DONE;
  always_comb begin
    live = '0;
    busy = '0;
    retired_n = retired;
    pcs_n = pcs;
    for (int i = 0; i < T; i++) begin
      live[i] = i < int'(thread_count);
      busy[i] = active_mask[i] && (lsu_state[2*i +: 2] == LSU_REQUESTING || lsu_state[2*i +: 2] == LSU_WAITING);
      retired_n[i] = retired[i] | (active_mask[i] & decoded_ret);
      pcs_n[i] = (active_mask[i] && !decoded_ret) ? nxt[i] : pcs[i];
    end
  end
  // candidate PCs/retire bits as they will stand after this UPDATE
  pc_min_select #(.T(T), .PC_BITS(PC_BITS)) u_min (
    .pcs(pcs_n),
    .valid(~retired_n),
    .min_pc(min_pc),
    .mask(min_mask),
    .any(min_any)
  );
  always_comb begin
    state_n = state;
    case (state)
      CS_IDLE:    if (start) state_n = thread_count == '0 ? CS_DONE : CS_FETCH;
      CS_FETCH:   if (fetcher_state == FETCHED) state_n = CS_DECODE;
      CS_DECODE:  state_n = CS_REQUEST;
      CS_REQUEST: state_n = CS_WAIT;
      CS_WAIT:    state_n = |busy ? CS_WAIT : CS_EXECUTE;
      CS_EXECUTE: state_n = CS_UPDATE;
      CS_UPDATE:  state_n = min_any ? CS_FETCH : CS_DONE;
      CS_DONE:    state_n = CS_DONE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CS_IDLE;
      current_pc <= '0;
      active_mask <= '0;
      pcs <= '0;
      retired <= '0;
    end else begin
      state <= state_n;
      if (state == CS_IDLE && start) begin
        retired <= ~live;
        pcs <= '0;
        current_pc <= '0;
        active_mask <= live;
      end
      if (state == CS_UPDATE) begin
        retired <= retired_n;
        pcs <= pcs_n;
        active_mask <= min_mask;
        if (min_any) current_pc <= min_pc;
      end
    end
`ifdef SIMT_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_cycles <= '0;
      perf_instr <= '0;
      perf_diverge <= '0;
    end else begin
      if (state != CS_IDLE && state != CS_DONE) perf_cycles <= perf_cycles + {31'd0, ~&perf_cycles};
      if (state == CS_UPDATE) begin
        perf_instr <= perf_instr + {31'd0, ~&perf_instr};
        if (min_mask != ~retired_n) perf_diverge <= perf_diverge + {15'd0, ~&perf_diverge};
      end
    end
`endif
endmodule
